// File: rtl/perf_counter_sched_if.sv
// Handshake/bus bundle between requesters, the shared event counter and the
// counter-sharing scheduler.
interface perf_counter_sched_if #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 32,
  parameter int WINDOW_W = 16
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]               req;
  logic [NREQ-1:0][WINDOW_W-1:0] req_window;
  logic [NREQ-1:0]               event_in;
  logic [NREQ-1:0]               ack;
  logic                          cnt_clr;
  logic                          cnt_en;
  logic [WIDTH-1:0]              cnt_value;
  logic [WIDTH-1:0]              result;
  logic [IDW-1:0]                result_id;
  logic                          result_valid;
  logic                          result_ready;
  logic                          busy;

  modport master (
    output req, req_window, event_in, cnt_value, result_ready,
    input  ack, cnt_clr, cnt_en, result, result_id, result_valid, busy
  );

  modport slave (
    input  req, req_window, event_in, cnt_value, result_ready,
    output ack, cnt_clr, cnt_en, result, result_id, result_valid, busy
  );
endinterface

// File: rtl/perf_counter_sched.sv
// Round-robin scheduler sharing one event counter among NREQ requesters:
// clear, count the granted requester's events over a window, return the count.
module perf_counter_sched #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 32,
  parameter int WINDOW_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  perf_counter_sched_if.slave bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, MEASURE, CAPTURE, DONE} state_t;

  state_t              state;
  logic [IDW-1:0]      rr_ptr;
  logic [IDW-1:0]      gnt;
  logic [IDW-1:0]      id_q;
  logic [IDW-1:0]      nxt_ptr;
  logic [WINDOW_W-1:0] wcnt;
  logic [WIDTH-1:0]    result_q;
  logic                clr_q;
  logic                valid_q;
  logic                busy_q;
  logic                any_req;
  logic                abort;
  logic [NREQ-1:0]     ack_c;

  // Lowest offset from rr_ptr wins, so scan offsets from the far end down.
  always_comb begin
    gnt     = rr_ptr;
    any_req = |bus.req;
    for (int k = NREQ-1; k >= 0; k--) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (bus.req[idx]) gnt = IDW'(idx);
    end
  end

  assign nxt_ptr = (id_q == IDW'(NREQ-1)) ? '0 : id_q + 1'b1;
  assign abort   = !bus.req[id_q];

  always_comb begin
    ack_c = '0;
    if (state == DONE && bus.result_ready) ack_c[id_q] = 1'b1;
  end

  // Enable and ack must follow event_in/result_ready in the same cycle.
  assign bus.cnt_en       = (state == MEASURE) && bus.event_in[id_q];
  assign bus.ack          = ack_c;
  assign bus.cnt_clr      = clr_q;
  assign bus.result       = result_q;
  assign bus.result_id    = id_q;
  assign bus.result_valid = valid_q;
  assign bus.busy         = busy_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      id_q     <= '0;
      wcnt     <= '0;
      result_q <= '0;
      clr_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          id_q   <= gnt;
          wcnt   <= bus.req_window[gnt];
          clr_q  <= 1'b1;
          busy_q <= 1'b1;
          state  <= CLEAR;
        end
        CLEAR: begin
          clr_q <= 1'b0;
          if (abort) begin
            rr_ptr <= nxt_ptr;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (wcnt == '0) begin
            state <= CAPTURE;
          end else begin
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (abort) begin
            rr_ptr <= nxt_ptr;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            wcnt <= wcnt - 1'b1;
            if (wcnt == WINDOW_W'(1)) state <= CAPTURE;
          end
        end
        CAPTURE: begin
          result_q <= bus.cnt_value;
          valid_q  <= 1'b1;
          state    <= DONE;
        end
        DONE: if (bus.result_ready) begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          rr_ptr  <= nxt_ptr;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_perf_counter_sched.sv
// Directed bench for perf_counter_sched with an external event-counter model.
module tb_perf_counter_sched;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  perf_counter_sched_if #(.NREQ(4), .WIDTH(32), .WINDOW_W(16)) bus ();

  perf_counter_sched #(.NREQ(4), .WIDTH(32), .WINDOW_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  // Shared counter: sync clear, +1 per enabled cycle.
  always @(posedge clk or negedge reset)
    if (!reset)           bus.cnt_value <= '0;
    else if (bus.cnt_clr) bus.cnt_value <= '0;
    else if (bus.cnt_en)  bus.cnt_value <= bus.cnt_value + 1;

  typedef struct {
    logic [3:0] rq;
    int w;
    int mode;   // 0 never, 1 always, 2 toggle starting at 1
    int dly;    // DONE cycles with ready low
    int eid;
    int eres;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input logic [3:0] rq, input int w);
    bus.req = rq;
    for (int i = 0; i < 4; i++) bus.req_window[i] = 16'(w);
  endtask

  task automatic run_txn(input logic [3:0] rq, input int w, input int mode,
                         input int dly, input int eid, input int eres);
    int nh;
    logic ev;
    logic [3:0] exp_ack;
    nh = w + 3 + dly;
    @(negedge clk);
    set_req(rq, w);
    bus.event_in = 4'hF;
    bus.result_ready = 1'b0;
    #1;
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_valid", 32'(bus.result_valid), 32'd0);
    for (int n = 1; n <= nh; n++) begin
      @(negedge clk);
      ev = (mode == 1) || (mode == 2 && ((n - 2) % 2 == 0));
      bus.event_in = 4'hF;
      bus.event_in[eid] = ev;
      bus.result_ready = (n < w + 3) ? 1'b1 : (n >= nh);
      if (n == 1) set_req(rq, w + 3);
      #1;
      chk("cnt_clr", 32'(bus.cnt_clr), 32'(n == 1));
      chk("cnt_en", 32'(bus.cnt_en), 32'((n >= 2) && (n <= w + 1) && ev));
      chk("busy", 32'(bus.busy), 32'd1);
      chk("valid", 32'(bus.result_valid), 32'(n >= w + 3));
      exp_ack = (n == nh) ? 4'(1 << eid) : 4'b0;
      chk("ack", 32'(bus.ack), 32'(exp_ack));
      if (n >= w + 3) begin
        chk("result", bus.result, 32'(eres));
        chk("result_id", 32'(bus.result_id), 32'(eid));
      end
    end
  endtask

  initial begin
    vt[0] = '{4'b0001, 5, 1, 0, 0, 5};
    vt[1] = '{4'b0010, 8, 2, 0, 1, 4};
    vt[2] = '{4'b1111, 2, 1, 0, 2, 2};
    vt[3] = '{4'b1111, 2, 2, 0, 3, 1};
    vt[4] = '{4'b1111, 2, 0, 0, 0, 0};
    vt[5] = '{4'b1111, 1, 1, 0, 1, 1};
    vt[6] = '{4'b0001, 0, 1, 10, 0, 0};
    vt[7] = '{4'b0101, 3, 1, 0, 2, 3};

    set_req(4'b0, 0);
    bus.event_in = '0;
    bus.result_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_valid", 32'(bus.result_valid), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_clr_en", 32'({bus.cnt_clr, bus.cnt_en}), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 8; i++)
      run_txn(vt[i].rq, vt[i].w, vt[i].mode, vt[i].dly, vt[i].eid, vt[i].eres);
    run_txn(4'b0011, 4, 2, 0, 0, 2);

    // Abort: req[2] dropped at c4 of a W=10 window; rr_ptr -> 3.
    @(negedge clk);
    set_req(4'b0100, 10);
    bus.event_in = 4'hF;
    bus.result_ready = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      bus.req = (n == 4) ? 4'b0 : 4'b0100;
      #1;
      chk("abort_cnt_en", 32'(bus.cnt_en), 32'(n >= 2));
    end
    for (int n = 5; n <= 6; n++) begin
      @(negedge clk);
      #1;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_cnt_en", 32'(bus.cnt_en), 32'd0);
      chk("abort_valid", 32'(bus.result_valid), 32'd0);
      chk("abort_ack", 32'(bus.ack), 32'd0);
    end
    run_txn(4'b1111, 1, 1, 0, 3, 1);
    run_txn(4'b0001, 1, 1, 0, 0, 1);

    // Reset in MEASURE with rr_ptr=1 and a nonzero held result.
    @(negedge clk);
    set_req(4'b0100, 10);
    bus.event_in = 4'hF;
    bus.result_ready = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_cnt_en", 32'(bus.cnt_en), 32'd0);
    chk("mid_rst_result", bus.result, 32'd0);
    chk("mid_rst_id", 32'(bus.result_id), 32'd0);
    chk("mid_rst_valid", 32'(bus.result_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    bus.req = 4'b0;
    run_txn(4'b1111, 2, 1, 0, 0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
